// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file.
package rf_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NRD    = 2;
   localparam int ZERO_ADDR  = 0;

   // One write port at the default widths: enable, target register, data.
   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wport_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: allocate sets, a write clears, and allocate
// beats a same-cycle write because the new producer is younger.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   output logic [(1<<ADDR_W)-1:0]   pend
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] pend_d;
   logic [DEPTH-1:0] pend_q;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_bit
         // Next pending state for register gi; the zero register never pends.
         always_comb begin
            pend_d[gi] = pend_q[gi];
            if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin
               pend_d[gi] = 1'b0;
            end else if (alloc && (alloc_addr == ADDR_W'(gi))) begin
               pend_d[gi] = 1'b1;
            end else if ((we0 && (waddr0 == ADDR_W'(gi))) ||
                         (we1 && (waddr1 == ADDR_W'(gi)))) begin
               pend_d[gi] = 1'b0;
            end
         end
      end
   endgenerate

   // Pending bit register, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD bypassed read ports, two write ports
// (W0 wins on collision), pending scoreboard and a registered debug port.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = 1
) (
   input  logic                    RF_CLK,
   input  logic                    RF_RST_N,
   input  logic                    RF_WE0,
   input  logic [ADDR_W-1:0]       RF_WADDR0,
   input  logic [DATA_W-1:0]       RF_WDATA0,
   input  logic                    RF_WE1,
   input  logic [ADDR_W-1:0]       RF_WADDR1,
   input  logic [DATA_W-1:0]       RF_WDATA1,
   input  logic                    RF_ALLOC,
   input  logic [ADDR_W-1:0]       RF_ALLOC_ADDR,
   input  logic [NRD*ADDR_W-1:0]   RF_RADDR,
   output logic [NRD*DATA_W-1:0]   RF_RDATA,
   output logic [NRD-1:0]          RF_RRDY,
   output logic [(1<<ADDR_W)-1:0]  RF_PEND,
   output logic                    RF_WCOLL,
   input  logic [ADDR_W-1:0]       RF_DBG_ADDR,
   output logic [DATA_W-1:0]       RF_DBG_DATA
);

   localparam int DEPTH   = 1 << ADDR_W;
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              wcoll_q;
   logic              wcoll_d;
   logic [DATA_W-1:0] dbg_data_q;
   logic [DATA_W-1:0] dbg_data_d;
   logic              wr0_en;
   logic              wr1_en;

   // Effective write enables: the zero register absorbs writes and W1
   // is dropped when it targets the same register as W0.
   always_comb begin
      wcoll_d = RF_WE0 && RF_WE1 && (RF_WADDR0 == RF_WADDR1);
      wr0_en  = RF_WE0 && !(ZERO_EN && (RF_WADDR0 == ADDR_W'(ZERO_ADDR)));
      wr1_en  = RF_WE1 && !(ZERO_EN && (RF_WADDR1 == ADDR_W'(ZERO_ADDR))) && !wcoll_d;
   end

   // Next array contents and debug sample (taken from the pre-write array).
   always_comb begin
      mem_d = mem_q;
      if (wr1_en) begin
         mem_d[RF_WADDR1] = RF_WDATA1;
      end
      if (wr0_en) begin
         mem_d[RF_WADDR0] = RF_WDATA0;
      end
      dbg_data_d = mem_q[RF_DBG_ADDR];
      if (ZERO_EN && (RF_DBG_ADDR == ADDR_W'(ZERO_ADDR))) begin
         dbg_data_d = '0;
      end
   end

   // Array, collision flag and debug register; everything clears on reset.
   always_ff @(posedge RF_CLK or negedge RF_RST_N) begin
      if (!RF_RST_N) begin
         mem_q      <= '{default: '0};
         wcoll_q    <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wcoll_q    <= wcoll_d;
         dbg_data_q <= dbg_data_d;
      end
   end

   assign RF_WCOLL    = wcoll_q;
   assign RF_DBG_DATA = dbg_data_q;

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (RF_CLK),
      .rst_n      (RF_RST_N),
      .alloc      (RF_ALLOC),
      .alloc_addr (RF_ALLOC_ADDR),
      .we0        (RF_WE0),
      .waddr0     (RF_WADDR0),
      .we1        (RF_WE1),
      .waddr1     (RF_WADDR1),
      .pend       (RF_PEND)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi = gi + 1) begin : g_rd
         logic [ADDR_W-1:0] raddr;
         logic [DATA_W-1:0] rdata;
         logic              rdy;
         logic              hit0;
         logic              hit1;
         logic              is_zero;

         assign raddr = RF_RADDR[gi*ADDR_W +: ADDR_W];

         // Read mux: zero register, then W0 bypass, then W1 bypass, then array.
         always_comb begin
            hit0    = RF_WE0 && (RF_WADDR0 == raddr);
            hit1    = RF_WE1 && (RF_WADDR1 == raddr);
            is_zero = ZERO_EN && (raddr == ADDR_W'(ZERO_ADDR));
            rdata   = mem_q[raddr];
            if (is_zero) begin
               rdata = '0;
            end else if (hit0) begin
               rdata = RF_WDATA0;
            end else if (hit1) begin
               rdata = RF_WDATA1;
            end
            rdy = is_zero || hit0 || hit1 || !RF_PEND[raddr];
         end

         assign RF_RDATA[gi*DATA_W +: DATA_W] = rdata;
         assign RF_RRDY[gi]                   = rdy;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sequence, then a vector table with
// same-cycle (combinational) and next-edge (registered) expectations.
module tb_regfile_mp;
   import rf_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        we0, we1, alloc;
   logic [4:0]  waddr0, waddr1, alloc_addr, dbg_addr;
   logic [31:0] wdata0, wdata1;
   logic [9:0]  raddr;
   logic [63:0] rdata, rdata_nz;
   logic [1:0]  rrdy, rrdy_nz;
   logic [31:0] pend, pend_nz;
   logic        wcoll, wcoll_nz;
   logic [31:0] dbg_data, dbg_data_nz;

   int checks   = 0;
   int failures = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut (
      .RF_CLK(clk), .RF_RST_N(rst_n),
      .RF_WE0(we0), .RF_WADDR0(waddr0), .RF_WDATA0(wdata0),
      .RF_WE1(we1), .RF_WADDR1(waddr1), .RF_WDATA1(wdata1),
      .RF_ALLOC(alloc), .RF_ALLOC_ADDR(alloc_addr),
      .RF_RADDR(raddr), .RF_RDATA(rdata), .RF_RRDY(rrdy),
      .RF_PEND(pend), .RF_WCOLL(wcoll),
      .RF_DBG_ADDR(dbg_addr), .RF_DBG_DATA(dbg_data)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0)) dut_nz (
      .RF_CLK(clk), .RF_RST_N(rst_n),
      .RF_WE0(we0), .RF_WADDR0(waddr0), .RF_WDATA0(wdata0),
      .RF_WE1(we1), .RF_WADDR1(waddr1), .RF_WDATA1(wdata1),
      .RF_ALLOC(alloc), .RF_ALLOC_ADDR(alloc_addr),
      .RF_RADDR(raddr), .RF_RDATA(rdata_nz), .RF_RRDY(rrdy_nz),
      .RF_PEND(pend_nz), .RF_WCOLL(wcoll_nz),
      .RF_DBG_ADDR(dbg_addr), .RF_DBG_DATA(dbg_data_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      wport_t      w0;
      wport_t      w1;
      logic        alloc;
      logic [4:0]  aaddr;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  dbg;
      logic [31:0] e_rd0;
      logic        e_rdy0;
      logic [31:0] e_rd1;
      logic        e_rdy1;
      logic [31:0] e_nz0;
      logic [31:0] e_pend;
      logic        e_wcoll;
      logic [31:0] e_dbg;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(
      input logic we0_i, input logic [4:0] a0, input logic [31:0] d0,
      input logic we1_i, input logic [4:0] a1, input logic [31:0] d1,
      input logic al, input logic [4:0] aa,
      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg,
      input logic [31:0] e_rd0, input logic e_rdy0,
      input logic [31:0] e_rd1, input logic e_rdy1,
      input logic [31:0] e_nz0, input logic [31:0] e_pend,
      input logic e_wcoll, input logic [31:0] e_dbg);
      vec_t v;
      v.w0 = '{we: we0_i, addr: a0, data: d0};
      v.w1 = '{we: we1_i, addr: a1, data: d1};
      v.alloc = al;   v.aaddr = aa;
      v.ra0 = r0;     v.ra1 = r1;    v.dbg = dbg;
      v.e_rd0 = e_rd0; v.e_rdy0 = e_rdy0;
      v.e_rd1 = e_rd1; v.e_rdy1 = e_rdy1;
      v.e_nz0 = e_nz0; v.e_pend = e_pend;
      v.e_wcoll = e_wcoll; v.e_dbg = e_dbg;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      we0 = v.w0.we; waddr0 = v.w0.addr; wdata0 = v.w0.data;
      we1 = v.w1.we; waddr1 = v.w1.addr; wdata1 = v.w1.data;
      alloc = v.alloc; alloc_addr = v.aaddr;
      raddr = {v.ra1, v.ra0}; dbg_addr = v.dbg;
      #1;
      chk($sformatf("v%0d_rd0", idx),  rdata[31:0],     v.e_rd0);
      chk($sformatf("v%0d_rdy0", idx), 32'(rrdy[0]),    32'(v.e_rdy0));
      chk($sformatf("v%0d_rd1", idx),  rdata[63:32],    v.e_rd1);
      chk($sformatf("v%0d_rdy1", idx), 32'(rrdy[1]),    32'(v.e_rdy1));
      chk($sformatf("v%0d_nz_rd0", idx), rdata_nz[31:0], v.e_nz0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pend", idx),  pend,           v.e_pend);
      chk($sformatf("v%0d_wcoll", idx), 32'(wcoll),     32'(v.e_wcoll));
      chk($sformatf("v%0d_dbg", idx),   dbg_data,       v.e_dbg);
      $display("vec %0d: w0=%0b/r%0d w1=%0b/r%0d alloc=%0b/r%0d rd0=0x%08h rd1=0x%08h pend=0x%08h wcoll=%0b dbg=0x%08h",
               idx, v.w0.we, v.w0.addr, v.w1.we, v.w1.addr, v.alloc, v.aaddr,
               rdata[31:0], rdata[63:32], pend, wcoll, dbg_data);
   endtask

   initial begin
      //           we0 a0  d0            we1 a1 d1     al aa  r0 r1 dbg  rd0           y0 rd1           y1 nz0           pend        wc dbg
      vecs[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0,  7, 8, 7,   32'hDEADBEEF, 1, 32'h0,        1, 32'hDEADBEEF, 32'h0,      0, 32'h0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  7, 0, 7,   32'hDEADBEEF, 1, 32'h0,        1, 32'hDEADBEEF, 32'h0,      0, 32'hDEADBEEF);
      vecs[2]  = mk(1, 3, 32'hA,        1, 3, 32'hB,  0, 0,  3, 7, 3,   32'hA,        1, 32'hDEADBEEF, 1, 32'hA,        32'h0,      1, 32'h0);
      vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  3, 7, 3,   32'hA,        1, 32'hDEADBEEF, 1, 32'hA,        32'h0,      0, 32'hA);
      vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 9,  9, 3, 3,   32'h0,        1, 32'hA,        1, 32'h0,        32'h200,    0, 32'hA);
      vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  9, 3, 3,   32'h0,        0, 32'hA,        1, 32'h0,        32'h200,    0, 32'hA);
      vecs[6]  = mk(0, 0, 32'h0,        1, 9, 32'h55, 0, 0,  9, 5, 9,   32'h55,       1, 32'h0,        1, 32'h55,       32'h0,      0, 32'h0);
      vecs[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  9, 5, 9,   32'h55,       1, 32'h0,        1, 32'h55,       32'h0,      0, 32'h55);
      vecs[8]  = mk(1, 4, 32'h77,       0, 0, 32'h0,  1, 4,  4, 9, 4,   32'h77,       1, 32'h55,       1, 32'h77,       32'h10,     0, 32'h0);
      vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  4, 9, 4,   32'h77,       0, 32'h55,       1, 32'h77,       32'h10,     0, 32'h77);
      vecs[10] = mk(1, 0, 32'hFFFF,     0, 0, 32'h0,  1, 0,  0, 4, 0,   32'h0,        1, 32'h77,       0, 32'hFFFF,     32'h10,     0, 32'h0);
      vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  0, 4, 0,   32'h0,        1, 32'h77,       0, 32'hFFFF,     32'h10,     0, 32'h0);
      vecs[12] = mk(1, 6, 32'h66,       1, 4, 32'h99, 0, 0,  4, 6, 6,   32'h99,       1, 32'h66,       1, 32'h99,       32'h0,      0, 32'h0);
      vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0,  4, 6, 6,   32'h99,       1, 32'h66,       1, 32'h99,       32'h0,      0, 32'h66);

      rst_n = 1'b0;
      we0 = 0; waddr0 = 0; wdata0 = 0;
      we1 = 0; waddr1 = 0; wdata1 = 0;
      alloc = 0; alloc_addr = 0; raddr = '0; dbg_addr = 0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pend",  pend,          32'h0);
      chk("rst_wcoll", 32'(wcoll),    32'h0);
      chk("rst_dbg",   dbg_data,      32'h0);
      chk("rst_rrdy",  32'(rrdy),     32'h3);
      chk("rst_rd0",   rdata[31:0],   32'h0);
      $display("reset: pend=0x%08h wcoll=%0b dbg=0x%08h rrdy=%b", pend, wcoll, dbg_data, rrdy);
      @(negedge clk);
      rst_n = 1'b1;

      // Write r5 and allocate r12, then reset mid-cycle.
      @(negedge clk);
      we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
      alloc = 1; alloc_addr = 12; dbg_addr = 5;
      @(negedge clk);
      we0 = 0; alloc = 0; raddr = {5'd0, 5'd5};
      @(posedge clk);
      #1;
      chk("pre_rst_dbg",  dbg_data,    32'h1234);
      chk("pre_rst_pend", pend,        32'h1000);
      chk("pre_rst_rd0",  rdata[31:0], 32'h1234);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dbg",  dbg_data,    32'h0);
      chk("mid_rst_pend", pend,        32'h0);
      chk("mid_rst_rd0",  rdata[31:0], 32'h0);
      chk("mid_rst_rdy0", 32'(rrdy[0]), 32'h1);
      $display("mid-cycle reset: dbg=0x%08h pend=0x%08h rd0=0x%08h rrdy0=%0b", dbg_data, pend, rdata[31:0], rrdy[0]);
      // A write presented while reset is held must be discarded.
      we0 = 1; waddr0 = 5; wdata0 = 32'hBAD;
      @(posedge clk);
      @(negedge clk);
      we0 = 0;
      rst_n = 1'b1;
      #1;
      chk("rst_discard_rd0", rdata[31:0], 32'h0);
      $display("write during reset: r5=0x%08h", rdata[31:0]);

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i], i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
